fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage. Owns the architectural fetch PC and drives it to the branch target buffer and the instruction memory port.
- Takes the next-PC prediction from the BTB and accepts misprediction redirects from ID.
- Runs the instruction-memory request handshake, including draining squashed requests.
- Loads the IF/ID pipeline register, which carries the pc+1 and predicted-target values ID uses to detect mispredictions.

Parameters:
- WORD_SIZE, 16, data/address width.
- RESET_PC, 16'h0000, first fetch address after reset.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall_id  in  1  ID cannot accept a new instruction this cycle.
- redirect  in  1  ID resolved a misprediction (flush code is not NICE_PRED).
- redirect_pc  in  WORD_SIZE  correct next PC when redirect=1.
- btb_next_pc  in  WORD_SIZE  BTB prediction for current pc (combinational from pc).
- pc  out  WORD_SIZE  current fetch PC; feeds the BTB lookup.
- i_readM  out  1  instruction-memory read request.
- i_address  out  WORD_SIZE  address of the outstanding request.
- inputReady  in  1  memory has completed the request; i_data valid this cycle.
- i_data  in  WORD_SIZE  instruction word.
- if_id_valid  out  1  IF/ID register holds a live instruction.
- if_id_instr  out  WORD_SIZE  fetched instruction.
- if_id_pc_1  out  WORD_SIZE  fetch address + 1 (mod 2^16).
- if_id_pred_pc  out  WORD_SIZE  btb_next_pc sampled when the instruction completed.
- fetched_count  out  WORD_SIZE  count of instructions loaded into IF/ID.

Behaviour:
- Reset (reset=1 at edge):
  - pc=RESET_PC, state=FETCH.
  - if_id_valid=0; if_id_instr, if_id_pc_1, if_id_pred_pc, fetched_count=0.
  - Hold buffer is cleared.
  - i_readM is 0 while reset is asserted and goes to 1 in the first cycle after.
  - Reset mid-request abandons the request. Memory must tolerate this.
- States:
  - FETCH: request at pc is outstanding.
  - HOLD: an instruction is captured in the hold buffer, waiting for IF/ID to free.
  - DRAIN: a squashed request is outstanding.
- Outputs by state:
  - i_readM=1 in FETCH and DRAIN, 0 in HOLD.
  - i_address=pc in FETCH. In DRAIN it equals drain_addr, the address of the squashed request, and stays stable until inputReady.
- IF/ID is "free" when if_id_valid=0 or stall_id=0. A non-free IF/ID holds all of its fields unchanged.
- FETCH, inputReady=1, redirect=0:
  - Completed word is {i_data, pc+1, btb_next_pc}.
  - pc<=btb_next_pc in every case.
  - IF/ID free: the word loads into IF/ID with if_id_valid<=1, fetched_count+1, and the state stays FETCH. This gives back-to-back single-cycle fetch.
  - IF/ID not free: the word goes to the hold buffer and the state goes to HOLD.
- FETCH, inputReady=0, redirect=0: hold pc and the request.
- HOLD, redirect=0: when IF/ID is free, the hold buffer loads into IF/ID (fetched_count+1) and the state goes to FETCH. Otherwise remain in HOLD.
- Redirect (highest priority, any state):
  - if_id_valid<=0 and the hold buffer is discarded, whatever stall_id says.
  - pc<=redirect_pc.
  - From FETCH with inputReady=1 the same cycle: discard i_data and go to FETCH.
  - From FETCH with inputReady=0: drain_addr<=old pc and go to DRAIN.
  - From HOLD: go to FETCH.
  - From DRAIN: pc updates to the newest redirect_pc. With inputReady=1 go to FETCH, otherwise stay in DRAIN.
- DRAIN, redirect=0: on inputReady, discard i_data and go to FETCH at pc. Never loads IF/ID.
- Arithmetic: if_id_pc_1 = pc+1 truncated to WORD_SIZE (16'hFFFF -> 16'h0000). fetched_count wraps 16'hFFFF -> 0 and is not cleared by redirect.
- Latency: an instruction enters IF/ID on the edge where inputReady=1, provided IF/ID is free. With stall_id low throughout, the throughput is one instruction per memory completion.

Test Plan:
- Reset release, memory always ready, BTB returns pc+1 -> i_address 0,1,2,3 on consecutive cycles. if_id_pc_1 = 1,2,3. if_id_valid=1 from cycle 1. fetched_count increments by 1 each cycle.
- BTB returns 16'h0040 for pc=3 -> next i_address 16'h0040. if_id_pred_pc for the pc=3 instruction = 16'h0040, and its if_id_pc_1 = 4.
- stall_id high 3 cycles while memory completes -> IF/ID frozen, state HOLD, i_readM=0. On release, the held instruction appears in the next cycle and fetched_count increases by exactly 1.
- Redirect to 16'h0100 while a request at 16'h0005 waits 2 cycles for inputReady -> i_address stays 16'h0005 until inputReady and its data is dropped (if_id_valid=0). The next request is at 16'h0100.
- Redirect coincident with inputReady and stall_id=1 -> if_id_valid<=0, data discarded, next i_address = redirect_pc. A second redirect during DRAIN -> the final target wins.
- pc=16'hFFFF completes -> if_id_pc_1=16'h0000. Reset asserted mid-DRAIN -> pc=RESET_PC, if_id_valid=0, fetched_count=0 next cycle.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, runs the instruction-memory
// handshake (including draining squashed requests) and loads IF/ID.
module fetch_unit #(
   parameter int unsigned    WORD_SIZE = 16,
   parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 stall_id,
   input  logic                 redirect,
   input  logic [WORD_SIZE-1:0] redirect_pc,
   input  logic [WORD_SIZE-1:0] btb_next_pc,
   output logic [WORD_SIZE-1:0] pc,
   output logic                 i_readM,
   output logic [WORD_SIZE-1:0] i_address,
   input  logic                 inputReady,
   input  logic [WORD_SIZE-1:0] i_data,
   output logic                 if_id_valid,
   output logic [WORD_SIZE-1:0] if_id_instr,
   output logic [WORD_SIZE-1:0] if_id_pc_1,
   output logic [WORD_SIZE-1:0] if_id_pred_pc,
   output logic [WORD_SIZE-1:0] fetched_count
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t                 state;
   state_t                 state_next;
   logic [WORD_SIZE-1:0]   pc_next;
   logic [WORD_SIZE-1:0]   pc_plus_1;
   logic [WORD_SIZE-1:0]   drain_addr;
   logic [WORD_SIZE-1:0]   hold_instr;
   logic [WORD_SIZE-1:0]   hold_pc_1;
   logic [WORD_SIZE-1:0]   hold_pred_pc;
   logic                   if_id_free;
   logic                   load_from_mem;
   logic                   load_from_hold;
   logic                   capture_hold;
   logic                   capture_drain;
   logic                   clear_valid;

   assign pc_plus_1  = pc + {{(WORD_SIZE-1){1'b0}}, 1'b1};
   assign if_id_free = !if_id_valid || !stall_id;
   assign i_readM    = !reset && (state != HOLD);
   assign i_address  = (state == DRAIN) ? drain_addr : pc;

   // Next-state and datapath control; redirect overrides everything else.
   always_comb begin
      state_next     = state;
      pc_next        = pc;
      load_from_mem  = 1'b0;
      load_from_hold = 1'b0;
      capture_hold   = 1'b0;
      capture_drain  = 1'b0;
      clear_valid    = 1'b0;
      if (redirect) begin
         pc_next     = redirect_pc;
         clear_valid = 1'b1;
         case (state)
            FETCH: begin
               if (inputReady) begin
                  state_next = FETCH;
               end else begin
                  state_next    = DRAIN;
                  capture_drain = 1'b1;
               end
            end
            HOLD:    state_next = FETCH;
            DRAIN:   state_next = inputReady ? FETCH : DRAIN;
            default: state_next = FETCH;
         endcase
      end else begin
         case (state)
            FETCH: begin
               if (inputReady) begin
                  pc_next = btb_next_pc;
                  if (if_id_free) begin
                     load_from_mem = 1'b1;
                  end else begin
                     capture_hold = 1'b1;
                     state_next   = HOLD;
                  end
               end else if (if_id_free) begin
                  clear_valid = 1'b1;
               end
            end
            HOLD: begin
               if (if_id_free) begin
                  load_from_hold = 1'b1;
                  state_next     = FETCH;
               end
            end
            DRAIN: begin
               clear_valid = if_id_free;
               if (inputReady) begin
                  state_next = FETCH;
               end
            end
            default: state_next = FETCH;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
      end else begin
         state <= state_next;
      end
   end

   // Fetch PC and the address of a squashed request still in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc         <= RESET_PC;
         drain_addr <= '0;
      end else begin
         pc <= pc_next;
         if (capture_drain) begin
            drain_addr <= pc;
         end
      end
   end

   // Hold buffer: parks a completed word while IF/ID is stalled.
   always_ff @(posedge clk) begin
      if (reset || redirect) begin
         hold_instr   <= '0;
         hold_pc_1    <= '0;
         hold_pred_pc <= '0;
      end else if (capture_hold) begin
         hold_instr   <= i_data;
         hold_pc_1    <= pc_plus_1;
         hold_pred_pc <= btb_next_pc;
      end
   end

   // IF/ID pipeline register and the count of instructions delivered to it.
   always_ff @(posedge clk) begin
      if (reset) begin
         if_id_valid   <= 1'b0;
         if_id_instr   <= '0;
         if_id_pc_1    <= '0;
         if_id_pred_pc <= '0;
         fetched_count <= '0;
      end else if (load_from_mem) begin
         if_id_valid   <= 1'b1;
         if_id_instr   <= i_data;
         if_id_pc_1    <= pc_plus_1;
         if_id_pred_pc <= btb_next_pc;
         fetched_count <= fetched_count + {{(WORD_SIZE-1){1'b0}}, 1'b1};
      end else if (load_from_hold) begin
         if_id_valid   <= 1'b1;
         if_id_instr   <= hold_instr;
         if_id_pc_1    <= hold_pc_1;
         if_id_pred_pc <= hold_pred_pc;
         fetched_count <= fetched_count + {{(WORD_SIZE-1){1'b0}}, 1'b1};
      end else if (clear_valid) begin
         if_id_valid <= 1'b0;
      end
   end

endmodule
